// File: rtl/wfb_pkg.sv
// wfb_pkg: shared op codes, read-source codes and buffer entry type for write_forward_buffer
package wfb_pkg;
  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_NOOP = 2'b11;
  localparam logic SRC_CACHE = 1'b0;
  localparam logic SRC_BUF = 1'b1;
  localparam int ENTRY_ADDR_W = 16;
  localparam int ENTRY_DATA_W = 32;
  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/wfb_match.sv
// wfb_match: address compare across all valid entries, picking the newest match (closest behind tail)
module wfb_match #(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_addrs,
  input  logic [ADDR_W-1:0]            i_key,
  input  logic [PW-1:0]                i_tail,
  output logic                         o_hit,
  output logic [PW-1:0]                o_idx
);
  logic [PW-1:0] w_pos;
  // walk oldest-to-newest so the last match (newest) wins
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    w_pos = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_pos = i_tail - PW'(k);
      if (i_valid[w_pos] && i_addrs[w_pos] == i_key) begin
        o_hit = 1'b1;
        o_idx = w_pos;
      end
    end
  end
endmodule

// File: rtl/write_forward_buffer.sv
// write_forward_buffer: in-order write FIFO to L1 with read forwarding; WFB_COALESCE_EN enables write coalescing
module write_forward_buffer
  import wfb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [1:0]             req_op,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   req_ready,
  output logic                   fwd_valid,
  output logic                   fwd_hit,
  output logic                   fwd_src,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   cache_wr_valid,
  input  logic                   cache_wr_ready,
  output logic [ADDR_W-1:0]      cache_wr_addr,
  output logic [DATA_W-1:0]      cache_wr_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0] r_count;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic r_fwd_valid, r_fwd_hit;
  logic [DATA_W-1:0] r_fwd_data;
  logic [DEPTH-1:0] w_valid;
  logic w_hit, w_is_wr, w_is_rd, w_pop, w_push, w_coalesce;
  logic [PW-1:0] w_idx;
  // an entry is live when its distance from head is below the occupancy
  always_comb begin
    w_valid = '0;
    for (int i = 0; i < DEPTH; i++) w_valid[i] = {1'b0, PW'(i) - r_head} < r_count;
  end
  wfb_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PW(PW)) u_match (
    .i_valid(w_valid),
    .i_addrs(r_addr),
    .i_key(req_addr),
    .i_tail(r_tail),
    .o_hit(w_hit),
    .o_idx(w_idx)
  );
  assign full = r_count == (PW+1)'(DEPTH);
  assign empty = r_count == '0;
  assign count = r_count;
  assign cache_wr_valid = !empty;
  assign cache_wr_addr = r_addr[r_head];
  assign cache_wr_data = r_data[r_head];
  assign w_is_wr = req_valid && req_op == OP_WR;
  assign w_is_rd = req_valid && req_op == OP_RD;
  assign w_pop = !empty && cache_wr_ready;
`ifdef WFB_COALESCE_EN
  // when full, only a match away from head is taken so req_ready never depends on cache_wr_ready
  assign req_ready = !full || req_op != OP_WR || (w_hit && w_idx != r_head);
  assign w_coalesce = w_is_wr && req_ready && w_hit && !(w_pop && w_idx == r_head);
`else
  assign req_ready = !full || req_op != OP_WR;
  assign w_coalesce = 1'b0;
`endif
  assign w_push = w_is_wr && req_ready && !w_coalesce;
  assign fwd_valid = r_fwd_valid;
  assign fwd_hit = r_fwd_hit;
  assign fwd_src = r_fwd_hit ? SRC_BUF : SRC_CACHE;
  assign fwd_data = r_fwd_data;
  // pointer and occupancy bookkeeping; reset discards pending entries
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  // entry storage: allocate at tail or overwrite a coalesced entry's data
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= req_addr;
      r_data[r_tail] <= req_wdata;
    end
    if (w_coalesce) r_data[w_idx] <= req_wdata;
  end
  // registered read lookup result, one cycle after an accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_valid <= 1'b0;
      r_fwd_hit <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_valid <= w_is_rd;
      r_fwd_hit <= w_is_rd && w_hit;
      r_fwd_data <= (w_is_rd && w_hit) ? r_data[w_idx] : '0;
    end
  end
endmodule

// File: tb/tb_write_forward_buffer.sv
// tb_write_forward_buffer: directed vectors with hand-computed expectations for write_forward_buffer
module tb_write_forward_buffer;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, fwd_valid, fwd_hit, fwd_src;
  logic cache_wr_valid, cache_wr_ready, full, empty;
  logic [1:0] req_op;
  logic [15:0] req_addr, cache_wr_addr;
  logic [31:0] req_wdata, fwd_data, cache_wr_data;
  logic [2:0] count;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  write_forward_buffer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .fwd_valid(fwd_valid), .fwd_hit(fwd_hit),
    .fwd_src(fwd_src), .fwd_data(fwd_data), .cache_wr_valid(cache_wr_valid),
    .cache_wr_ready(cache_wr_ready), .cache_wr_addr(cache_wr_addr), .cache_wr_data(cache_wr_data),
    .count(count), .full(full), .empty(empty)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic v, input logic [1:0] op, input logic [15:0] a, input logic [31:0] d);
    req_valid = v;
    req_op = op;
    req_addr = a;
    req_wdata = d;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    cache_wr_ready = 1'b0;
    req(1'b0, 2'b11, 16'h0, 32'h0);
    step();
    step();
    rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_cwv", 32'(cache_wr_valid), 32'd0);
    check("rst_fwdv", 32'(fwd_valid), 32'd0);
    // read miss on empty buffer
    req(1'b1, 2'b00, 16'h0010, 32'h0);
    step();
    req(1'b0, 2'b00, 16'h0, 32'h0);
    check("miss_valid", 32'(fwd_valid), 32'd1);
    check("miss_hit", 32'(fwd_hit), 32'd0);
    check("miss_src", 32'(fwd_src), 32'd0);
    check("miss_data", fwd_data, 32'h0);
    check("miss_empty", 32'(empty), 32'd1);
    step();
    check("fwd_pulse", 32'(fwd_valid), 32'd0);
    // noop and reserved op leave state alone
    req(1'b1, 2'b10, 16'h0010, 32'h5);
    step();
    check("noop_fwdv", 32'(fwd_valid), 32'd0);
    check("noop_count", 32'(count), 32'd0);
    // write then read next cycle forwards
    req(1'b1, 2'b01, 16'h0020, 32'hDEADBEEF);
    step();
    req(1'b1, 2'b00, 16'h0020, 32'h0);
    check("wr_count", 32'(count), 32'd1);
    check("wr_cwv", 32'(cache_wr_valid), 32'd1);
    check("wr_caddr", 32'(cache_wr_addr), 32'h0020);
    step();
    check("fwd_hit", 32'(fwd_hit), 32'd1);
    check("fwd_src", 32'(fwd_src), 32'd1);
    check("fwd_data", fwd_data, 32'hDEADBEEF);
    // read of the entry being drained this same cycle still forwards
    cache_wr_ready = 1'b1;
    req(1'b1, 2'b00, 16'h0020, 32'h0);
    step();
    cache_wr_ready = 1'b0;
    req(1'b0, 2'b00, 16'h0, 32'h0);
    check("drainrd_hit", 32'(fwd_hit), 32'd1);
    check("drainrd_data", fwd_data, 32'hDEADBEEF);
    check("drainrd_empty", 32'(empty), 32'd1);
    // fill to full
    for (int i = 1; i <= 4; i++) begin
      req(1'b1, 2'b01, 16'(i), 32'h100 + 32'(i));
      step();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    req(1'b1, 2'b01, 16'h0005, 32'h105);
    check("full_wr_ready", 32'(req_ready), 32'd0);
    req(1'b1, 2'b00, 16'h0003, 32'h0);
    check("full_rd_ready", 32'(req_ready), 32'd1);
    step();
    req(1'b0, 2'b00, 16'h0, 32'h0);
    check("full_rd_data", fwd_data, 32'h103);
    cache_wr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_addr", 32'(cache_wr_addr), 32'(i));
      check("drain_data", cache_wr_data, 32'h100 + 32'(i));
      step();
    end
    cache_wr_ready = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    // duplicate address writes, newest data forwarded
    req(1'b1, 2'b01, 16'h0030, 32'h11);
    step();
    req(1'b1, 2'b01, 16'h0030, 32'h22);
    step();
    req(1'b1, 2'b00, 16'h0030, 32'h0);
`ifdef WFB_COALESCE_EN
    check("dup_count", 32'(count), 32'd1);
`else
    check("dup_count", 32'(count), 32'd2);
`endif
    step();
    req(1'b0, 2'b00, 16'h0, 32'h0);
    check("dup_data", fwd_data, 32'h22);
    cache_wr_ready = 1'b1;
    repeat (3) step();
    cache_wr_ready = 1'b0;
    check("dup_empty", 32'(empty), 32'd1);
    // full with simultaneous write and drain: write waits one cycle
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 2'b01, 16'h0040 + 16'(i), 32'h200 + 32'(i));
      step();
    end
    cache_wr_ready = 1'b1;
    req(1'b1, 2'b01, 16'h0050, 32'h250);
    check("fullpop_ready", 32'(req_ready), 32'd0);
    step();
    cache_wr_ready = 1'b0;
    #1;
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_ready2", 32'(req_ready), 32'd1);
    step();
    req(1'b0, 2'b00, 16'h0, 32'h0);
    check("refill_count", 32'(count), 32'd4);
    check("refill_full", 32'(full), 32'd1);
    cache_wr_ready = 1'b1;
    check("wrap_addr0", 32'(cache_wr_addr), 32'h0041);
    step();
    check("wrap_addr1", 32'(cache_wr_addr), 32'h0042);
    step();
    cache_wr_ready = 1'b0;
    #1;
    check("mid_cwv", 32'(cache_wr_valid), 32'd1);
    check("mid_count", 32'(count), 32'd2);
    // reset mid-drain discards pending entries
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_cwv", 32'(cache_wr_valid), 32'd0);
    req(1'b1, 2'b00, 16'h0043, 32'h0);
    step();
    req(1'b0, 2'b00, 16'h0, 32'h0);
    check("mrst_fwdv", 32'(fwd_valid), 32'd1);
    check("mrst_hit", 32'(fwd_hit), 32'd0);
    check("mrst_data", fwd_data, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
